// File: rtl/hdmi_wordsync_if.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_wordsync_if
//  Description : Word-stream bundle between the TMDS deserializer/control side
//                and the word-alignment stage of one TMDS channel.
//  Revision    : 1.0  initial release
// ============================================================================
interface hdmi_wordsync_if;
  logic       i_ce;
  logic [9:0] i_word;
  logic       i_manual;
  logic [3:0] i_manual_shift;
  logic [9:0] o_word;
  logic       o_is_ctl;
  logic [1:0] o_ctl;
  logic       o_locked;
  logic [3:0] o_shift;

  // Source side: drives raw words and the manual override, observes results
  modport master (
    output i_ce, i_word, i_manual, i_manual_shift,
    input  o_word, o_is_ctl, o_ctl, o_locked, o_shift
  );

  // Aligner side
  modport slave (
    input  i_ce, i_word, i_manual, i_manual_shift,
    output o_word, o_is_ctl, o_ctl, o_locked, o_shift
  );
endinterface
`default_nettype wire

// File: rtl/hdmi_wordsync.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_wordsync
//  Description : TMDS word aligner. Tries each of the ten bit rotations of the
//                raw deserializer stream, locks on repeated control tokens and
//                presents aligned words, token flags and lock status.
//  Revision    : 1.0  initial release
// ============================================================================
module hdmi_wordsync #(
  parameter int LOCK_COUNT     = 4,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 65536
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  hdmi_wordsync_if.slave bus
);

  // Counter widths; a one-bit floor keeps degenerate parameter values legal
  localparam int c_match_w  = (LOCK_COUNT     > 1) ? $clog2(LOCK_COUNT)     : 1;
  localparam int c_search_w = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int c_loss_w   = (LOSS_TIMEOUT   > 1) ? $clog2(LOSS_TIMEOUT)   : 1;

  localparam logic [c_match_w-1:0]  c_match_last  = c_match_w'(LOCK_COUNT - 1);
  localparam logic [c_search_w-1:0] c_search_last = c_search_w'(SEARCH_TIMEOUT - 1);
  localparam logic [c_loss_w-1:0]   c_loss_last   = c_loss_w'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                r_state;
  logic [9:0]            r_prev;
  logic [9:0]            r_cur;
  logic [9:0]            r_word;
  logic                  r_is_ctl;
  logic [1:0]            r_ctl;
  logic                  r_locked;
  logic [3:0]            r_shift;
  logic                  r_settle;
  logic [c_match_w-1:0]  r_match;
  logic [c_search_w-1:0] r_search;
  logic [c_loss_w-1:0]   r_loss;

  logic [19:0] w_hist;
  logic [19:0] w_rot;
  logic [9:0]  w_aligned;
  logic        w_is_ctl;
  logic [1:0]  w_ctl;
  logic [3:0]  w_manual_shift;

  // The two most recent raw words form a 20-bit window; the shift picks 10 bits
  assign w_hist         = {r_prev, r_cur};
  assign w_rot          = w_hist >> r_shift;
  assign w_aligned      = w_rot[9:0];
  assign w_manual_shift = (bus.i_manual_shift > 4'd9) ? 4'd9 : bus.i_manual_shift;

  // Recognise the four TMDS control tokens in the aligned candidate word
  always_comb begin
    w_is_ctl = 1'b1;
    w_ctl    = 2'b00;
    case (w_aligned)
      10'h354: w_ctl = 2'b00;
      10'h0AB: w_ctl = 2'b01;
      10'h154: w_ctl = 2'b10;
      10'h2AB: w_ctl = 2'b11;
      default: w_is_ctl = 1'b0;
    endcase
  end

  // Word history and registered aligned output, advancing on valid beats only
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prev   <= 10'd0;
      r_cur    <= 10'd0;
      r_word   <= 10'd0;
      r_is_ctl <= 1'b0;
      r_ctl    <= 2'b00;
    end else if (bus.i_ce) begin
      r_prev   <= r_cur;
      r_cur    <= bus.i_word;
      r_word   <= w_aligned;
      r_is_ctl <= w_is_ctl;
      r_ctl    <= w_ctl;
    end
  end

  // Alignment search / settle / lock controller; judges the word on o_word
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_SEARCH;
      r_shift  <= 4'd0;
      r_locked <= 1'b0;
      r_settle <= 1'b0;
      r_match  <= '0;
      r_search <= '0;
      r_loss   <= '0;
    end else if (bus.i_ce) begin
      if (bus.i_manual) begin
        r_state  <= ST_SEARCH;
        r_shift  <= w_manual_shift;
        r_locked <= 1'b0;
        r_settle <= 1'b0;
        r_match  <= '0;
        r_search <= '0;
        r_loss   <= '0;
      end else begin
        case (r_state)
          ST_SEARCH: begin
            // Lock takes priority over a simultaneous timeout
            if (r_is_ctl && (r_match == c_match_last)) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_match  <= '0;
              r_search <= '0;
              r_loss   <= '0;
            end else if (r_search == c_search_last) begin
              r_state  <= ST_SETTLE;
              r_shift  <= (r_shift == 4'd9) ? 4'd0 : r_shift + 4'd1;
              r_match  <= '0;
              r_search <= '0;
              r_settle <= 1'b0;
            end else begin
              r_search <= r_search + 1'b1;
              r_match  <= r_is_ctl ? r_match + 1'b1 : '0;
            end
          end
          ST_SETTLE: begin
            // Two words built with the previous shift are still in flight
            if (r_settle) begin
              r_settle <= 1'b0;
              r_state  <= ST_SEARCH;
            end else begin
              r_settle <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (r_is_ctl) begin
              r_loss <= '0;
            end else if (r_loss == c_loss_last) begin
              r_state  <= ST_SEARCH;
              r_locked <= 1'b0;
              r_match  <= '0;
              r_search <= '0;
              r_loss   <= '0;
            end else begin
              r_loss <= r_loss + 1'b1;
            end
          end
          default: r_state <= ST_SEARCH;
        endcase
      end
    end
  end

  assign bus.o_word   = r_word;
  assign bus.o_is_ctl = r_is_ctl;
  assign bus.o_ctl    = r_ctl;
  assign bus.o_locked = r_locked;
  assign bus.o_shift  = r_shift;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_wordsync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdmi_wordsync
//  Description : Scoreboard bench for hdmi_wordsync with a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hdmi_wordsync;
  localparam int LOCK_COUNT     = 4;
  localparam int SEARCH_TIMEOUT = 2048;
  localparam int LOSS_TIMEOUT   = 16;
  localparam logic [9:0] c_tok  = 10'h354;
  localparam logic [9:0] c_data = 10'h1F0;

  logic i_clk     = 1'b0;
  logic i_reset_n = 1'b0;

  hdmi_wordsync_if bus ();

  hdmi_wordsync #(
    .LOCK_COUNT    (LOCK_COUNT),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .LOSS_TIMEOUT  (LOSS_TIMEOUT)
  ) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .bus      (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [9:0] word;
    logic       is_ctl;
    logic [1:0] ctl;
    logic       locked;
    logic [3:0] shift;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp;
  obs_t mon_act;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_beat   = 0;

  // ---------------- behavioural reference model ----------------
  logic [9:0] m_prev, m_cur, m_word;
  logic       m_is_ctl, m_locked;
  logic [1:0] m_ctl;
  int         m_shift, m_phase, m_run, m_age, m_flush, m_quiet; // phase: 0 hunt, 1 flush, 2 locked

  function automatic int tok_index(input logic [9:0] w);
    logic [9:0] toks [4];
    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    for (int k = 0; k < 4; k++) if (w == toks[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_cur = '0; m_word = '0; m_is_ctl = 0; m_ctl = '0; m_locked = 0;
    m_shift = 0; m_phase = 0; m_run = 0; m_age = 0; m_flush = 0; m_quiet = 0;
  endtask

  task automatic model_step(input logic ce, input logic [9:0] w, input logic man, input logic [3:0] ms);
    logic [19:0] pair;
    logic [9:0]  seen;
    bit          tok_was;
    int          idx;
    if (!ce) return;
    pair    = {m_prev, m_cur};
    seen    = 10'(pair >> m_shift);
    tok_was = m_is_ctl;
    idx     = tok_index(seen);
    m_word   = seen;
    m_is_ctl = (idx >= 0);
    m_ctl    = (idx >= 0) ? 2'(idx) : 2'b00;
    m_prev   = m_cur;
    m_cur    = w;
    if (man) begin
      m_shift = (ms > 9) ? 9 : int'(ms);
      m_phase = 0; m_run = 0; m_age = 0; m_flush = 0; m_quiet = 0; m_locked = 0;
      return;
    end
    case (m_phase)
      0: begin
        m_run = tok_was ? m_run + 1 : 0;
        if (m_run == LOCK_COUNT) begin
          m_phase = 2; m_locked = 1; m_run = 0; m_age = 0; m_quiet = 0;
        end else if (m_age == SEARCH_TIMEOUT - 1) begin
          m_shift = (m_shift + 1) % 10; m_run = 0; m_age = 0; m_flush = 0; m_phase = 1;
        end else begin
          m_age++;
        end
      end
      1: begin
        m_flush++;
        if (m_flush == 2) begin m_phase = 0; m_flush = 0; end
      end
      default: begin
        if (tok_was) m_quiet = 0;
        else begin
          m_quiet++;
          if (m_quiet == LOSS_TIMEOUT) begin
            m_phase = 0; m_locked = 0; m_run = 0; m_age = 0; m_quiet = 0;
          end
        end
      end
    endcase
  endtask

  // ---------------- stimulus: logical words serialized at rotation g_rot ----------------
  logic [9:0] g_pend = c_tok;
  int         g_rot  = 3;

  task automatic beat(input logic rst_n, input logic ce, input logic [9:0] next_logical,
                      input logic man, input logic [3:0] ms);
    logic [19:0] two;
    logic [9:0]  raw;
    @(negedge i_clk);
    if (ce) begin
      two    = {g_pend, next_logical};
      raw    = 10'(two >> (10 - g_rot));
      g_pend = next_logical;
    end else begin
      raw = 10'($urandom);
    end
    i_reset_n          = rst_n;
    bus.i_ce           = ce;
    bus.i_word         = raw;
    bus.i_manual       = man;
    bus.i_manual_shift = ms;
    if (rst_n) model_step(ce, raw, man, ms);
    else       model_reset();
    exp_q.push_back('{m_word, m_is_ctl, m_ctl, m_locked, 4'(m_shift)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor: one expected observation per clock ----------------
  always @(posedge i_clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = '{bus.o_word, bus.o_is_ctl, bus.o_ctl, bus.o_locked, bus.o_shift};
      n_beat++;
      n_checks++;
      if (mon_act === mon_exp) n_pass++;
      else $display("FAIL beat_%0d: got word=%h is_ctl=%b ctl=%b locked=%b shift=%0d, expected word=%h is_ctl=%b ctl=%b locked=%b shift=%0d",
                    n_beat, mon_act.word, mon_act.is_ctl, mon_act.ctl, mon_act.locked, mon_act.shift,
                    mon_exp.word, mon_exp.is_ctl, mon_exp.ctl, mon_exp.locked, mon_exp.shift);
    end
  end

  task automatic acquire(input string name);
    bit got;
    got = 0;
    for (int k = 0; k < 10 * (SEARCH_TIMEOUT + 2) + LOCK_COUNT + 6; k++) begin
      beat(1, 1, c_tok, 0, 4'd0);
      if (bus.o_locked) begin got = 1; break; end
    end
    check({name, "_locked"}, 32'(got), 32'd1);
    check({name, "_shift"}, 32'(bus.o_shift), 32'd3);
    repeat (3) beat(1, 1, c_tok, 0, 4'd0);
    check({name, "_word"}, 32'(bus.o_word), 32'h354);
    check({name, "_ctl"}, 32'(bus.o_ctl), 32'd0);
  endtask

  task automatic relock(input string name);
    bit got;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      beat(1, 1, c_tok, 0, 4'd0);
      if (bus.o_locked) begin got = 1; break; end
    end
    check(name, 32'(got), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_ce = 0; bus.i_word = '0; bus.i_manual = 0; bus.i_manual_shift = '0;
    model_reset();

    // Reset held with random activity on the inputs
    repeat (6) beat(0, 1'($urandom), 10'($urandom), 0, 4'd0);
    check("reset_word",   32'(bus.o_word),   32'd0);
    check("reset_locked", 32'(bus.o_locked), 32'd0);
    check("reset_shift",  32'(bus.o_shift),  32'd0);

    // Acquire a continuous 0x354 stream at rotation 3, then stay stable
    acquire("acq1");
    for (int k = 0; k < 40; k++) beat(1, 1'($urandom_range(0, 1)), c_tok, 0, 4'd0);

    // Loss of lock: a token at data word 10 restarts the count
    repeat (9)  beat(1, 1, c_data, 0, 4'd0);
    beat(1, 1, c_tok, 0, 4'd0);
    repeat (15) beat(1, 1, c_data, 0, 4'd0);
    check("loss_restart_locked", 32'(bus.o_locked), 32'd1);
    repeat (20) beat(1, 1, c_data, 0, 4'd0);
    check("loss_unlocked", 32'(bus.o_locked), 32'd0);
    check("loss_shift",    32'(bus.o_shift),  32'd3);
    relock("relock_after_loss");

    // Broken run: 3 tokens, data, 3 tokens must not lock; a 4th token does
    repeat (5) beat(1, 1, c_data, 1, 4'd3);
    check("manual3_unlocked", 32'(bus.o_locked), 32'd0);
    repeat (2) beat(1, 1, c_data, 0, 4'd0);
    repeat (3) beat(1, 1, c_tok, 0, 4'd0);
    beat(1, 1, c_data, 0, 4'd0);
    repeat (3) beat(1, 1, c_tok, 0, 4'd0);
    repeat (6) beat(1, 1, c_data, 0, 4'd0);
    check("broken_run_nolock", 32'(bus.o_locked), 32'd0);
    repeat (3) beat(1, 1, c_tok, 0, 4'd0);
    beat(1, 1, c_data, 0, 4'd0);
    repeat (4) beat(1, 1, c_tok, 0, 4'd0);
    repeat (6) beat(1, 1, c_data, 0, 4'd0);
    check("fourth_token_lock", 32'(bus.o_locked), 32'd1);

    // Manual shift clamp and i_ce gated 1-of-3
    for (int k = 0; k < 30; k++) beat(1, (k % 3) == 0, 10'($urandom), 1, 4'd12);
    check("manual_clamp_shift", 32'(bus.o_shift),  32'd9);
    check("manual_unlocked",    32'(bus.o_locked), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++)
      beat(1, 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0) ? c_tok : 10'($urandom),
           1'($urandom_range(0, 15) == 0), 4'($urandom));

    // Lock at shift 3, then reset asynchronously mid-cycle and reacquire
    repeat (3) beat(1, 1, c_data, 1, 4'd3);
    relock("relock_before_reset");
    @(posedge i_clk);
    #3;
    i_reset_n = 0;
    model_reset();
    #1;
    check("async_word",   32'(bus.o_word),   32'd0);
    check("async_ctl",    32'(bus.o_is_ctl), 32'd0);
    check("async_locked", 32'(bus.o_locked), 32'd0);
    check("async_shift",  32'(bus.o_shift),  32'd0);
    repeat (3) beat(0, 1'($urandom), 10'($urandom), 0, 4'd0);
    acquire("acq2");

    @(posedge i_clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
